ped_req_ctl: RTL
================

PED_REQ_CTL -- requirements
Module: ped_req_ctl

Interface
REQ-001 Parameter: DEB_CYC, default 3, consecutive synchronized-high cycles required to accept a button press (legal 1..15).
REQ-002 Parameter: COOL_CYC, default 10, cycles after a pedestrian phase during which no new request is issued (legal 1..255).
REQ-003 Port: clk  input  1  single clock (1 Hz system tick); all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: btn  input  1  raw pedestrian push-button, asynchronous to clk, may bounce.
REQ-006 Port: Pg  input  1  pedestrian-green from the downstream light controller (same clock domain).
REQ-007 Port: N  output  1  registered pedestrian request level to the light controller.
REQ-008 Port: pending  output  1  registered "request waiting" lamp.
REQ-009 Port: served_cnt  output  8  registered count of requests served.

Function
REQ-010 btn SHALL pass through a 2-flop synchronizer; btn_s denotes its output.
REQ-011 Debounce counter SHALL increment at each edge with btn_s=1, saturate at DEB_CYC, and clear at any edge with btn_s=0.
REQ-012 A press event SHALL occur at the edge where btn_s=1 and the counter equals DEB_CYC-1; at most one event per press, and a new event requires btn_s=0 first.
REQ-013 With btn stable high before edge 0 (first sampling edge), the press event and the IDLE->PENDING transition SHALL occur at edge DEB_CYC+1.
REQ-014 FSM states SHALL be IDLE, PENDING, SERVING, COOLDOWN.
REQ-015 IDLE: Pg=1 -> SERVING; else press event -> PENDING; else stay.
REQ-016 IDLE with press event and Pg=1 on the same edge SHALL go to SERVING and drop the press.
REQ-017 PENDING: N=1, pending=1; Pg=1 -> SERVING, incrementing served_cnt by 1 on that edge.
REQ-018 SERVING: N=0, pending=0; press events SHALL be ignored; Pg=0 -> COOLDOWN, loading the cooldown counter with COOL_CYC.
REQ-019 COOLDOWN: cooldown counter SHALL decrement by 1 per edge; a press event SHALL set a latched-request flag.
REQ-020 COOLDOWN SHALL exit at the edge where the counter equals 1: to PENDING if the flag is set or a press event occurs on that edge, else to IDLE; the flag SHALL clear on exit.
REQ-021 Pg=1 during COOLDOWN SHALL move to SERVING and clear the flag, without incrementing served_cnt.
REQ-022 served_cnt SHALL wrap from 255 to 0.
REQ-023 N and pending SHALL be decoded from registered state only, with no combinational path from btn or Pg.

Reset
REQ-024 rst=0 SHALL immediately force state IDLE, N=0, pending=0, served_cnt=0, synchronizer flops 0, debounce counter 0, cooldown counter 0, flag 0, regardless of clk.
REQ-025 After rst returns to 1, a button held through reset SHALL be debounced from zero, with no event before edge DEB_CYC+1.

Verification
REQ-026 DEB_CYC=3, btn high from edge 0, Pg=0 -> N=1, pending=1 after edge 4; Pg=1 at edge 10 -> N=0 after edge 10, served_cnt=1.
REQ-027 btn pulses giving btn_s=1 for only 2 consecutive edges, repeated 5 times -> N stays 0, state stays IDLE.
REQ-028 btn held 50 cycles, served (Pg 1 for 5 cycles), COOL_CYC=10 -> single served_cnt increment, state IDLE after cooldown, N stays 0 until release and re-press.
REQ-029 Press event during COOLDOWN cycle 3 -> N=1 on the edge the cooldown counter equals 1, with no further press.
REQ-030 rst driven low between edges while in PENDING -> N=0 and served_cnt=0 immediately, before the next clk edge.
REQ-031 256 complete request/serve cycles -> served_cnt reads 0, and 1 after the 257th serve.

Source files
------------

// File: rtl/ped_req_ctl.sv
// Pedestrian request controller: synchronizes and debounces the push-button and
// sequences requests to the light controller through IDLE/PENDING/SERVING/COOLDOWN.
module ped_req_ctl #(
  parameter int DEB_CYC  = 3,
  parameter int COOL_CYC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       Pg,
  output logic       N,
  output logic       pending,
  output logic [7:0] served_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    SERVING  = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam logic [3:0] DEB_MAX   = 4'(DEB_CYC);
  localparam logic [3:0] DEB_FIRE  = 4'(DEB_CYC - 1);
  localparam logic [7:0] COOL_LOAD = 8'(COOL_CYC);

  state_t     r_state;
  logic       r_sync1;
  logic       r_sync2;
  logic [3:0] r_deb_cnt;
  logic [7:0] r_cool_cnt;
  logic       r_flag;
  logic       r_n;
  logic       r_pending;
  logic [7:0] r_served;

  logic       w_press;

  // Fires only on the edge the counter passes DEB_CYC-1; saturation keeps a held button quiet.
  assign w_press = r_sync2 && (r_deb_cnt == DEB_FIRE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_deb_cnt <= 4'd0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      if (!r_sync2)
        r_deb_cnt <= 4'd0;
      else if (r_deb_cnt != DEB_MAX)
        r_deb_cnt <= r_deb_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cool_cnt <= 8'd0;
      r_flag     <= 1'b0;
      r_n        <= 1'b0;
      r_pending  <= 1'b0;
      r_served   <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Pg) begin
            r_state <= SERVING;
          end else if (w_press) begin
            r_state   <= PENDING;
            r_n       <= 1'b1;
            r_pending <= 1'b1;
          end
        end
        PENDING: begin
          if (Pg) begin
            r_state   <= SERVING;
            r_n       <= 1'b0;
            r_pending <= 1'b0;
            r_served  <= r_served + 8'd1;
          end
        end
        SERVING: begin
          if (!Pg) begin
            r_state    <= COOLDOWN;
            r_cool_cnt <= COOL_LOAD;
          end
        end
        COOLDOWN: begin
          if (Pg) begin
            r_state    <= SERVING;
            r_flag     <= 1'b0;
            r_cool_cnt <= 8'd0;
          end else if (r_cool_cnt == 8'd1) begin
            r_flag     <= 1'b0;
            r_cool_cnt <= 8'd0;
            if (r_flag || w_press) begin
              r_state   <= PENDING;
              r_n       <= 1'b1;
              r_pending <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cool_cnt <= r_cool_cnt - 8'd1;
            if (w_press)
              r_flag <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_n       <= 1'b0;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  assign N          = r_n;
  assign pending    = r_pending;
  assign served_cnt = r_served;

endmodule
